// File: rtl/smpl_seq_pkg.sv
// Shared definitions for the smpl_circuit self-test sequencer.
// Covers the FSM state encoding, pattern/result sizing and the busy-state decode.
package smpl_seq_pkg;

    localparam int PAT_W   = 3;
    localparam int NUM_PAT = 8;
    localparam int RES_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_DRIVE) || (s == ST_SETTLE) || (s == ST_SAMPLE);
    endfunction

endpackage

// File: rtl/smpl_ref_model.sv
// Combinational golden model of smpl_circuit: x = (A&B)|~C, y = ~C.
module smpl_ref_model (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic x_exp_o,
    output logic y_exp_o
);

    assign x_exp_o = (a_i & b_i) | ~c_i;
    assign y_exp_o = ~c_i;

endmodule

// File: rtl/smpl_circuit_seq.sv
// Self-test sequencer: drives A/B/C patterns into smpl_circuit, waits a settle window,
// samples x/y into result_map and counts mismatches against the golden model.
module smpl_circuit_seq
    import smpl_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [2:0]       pattern_in,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    input  logic             dut_x,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result_map,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass,
    output logic [2:0]       dbg_state_o
);

    localparam int SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               mode_q, mode_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [PAT_W-1:0]   drv_q, drv_d;
    logic [RES_W-1:0]   map_q, map_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;

    logic               x_exp, y_exp;
    logic [1:0]         sample;
    logic               sample_bad;

    smpl_ref_model u_ref (
        .a_i     (drv_q[2]),
        .b_i     (drv_q[1]),
        .c_i     (drv_q[0]),
        .x_exp_o (x_exp),
        .y_exp_o (y_exp)
    );

    assign sample     = {dut_y, dut_x};
    assign sample_bad = (sample != {y_exp, x_exp});

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        mode_d    = mode_q;
        set_cnt_d = set_cnt_q;
        drv_d     = drv_q;
        map_d     = map_q;
        err_d     = err_q;
        pass_d    = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    mode_d  = mode;
                    pat_d   = mode ? pattern_in : '0;
                    drv_d   = mode ? pattern_in : '0;
                    map_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                set_cnt_d = '0;
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                for (int p = 0; p < NUM_PAT; p++) begin
                    if (pat_q == PAT_W'(p)) begin
                        map_d[2*p +: 2] = sample;
                    end
                end
                if (sample_bad && (err_q != ERR_MAX)) begin
                    err_d = err_q + 1'b1;
                end
                if (mode_q || (pat_q == PAT_LAST)) begin
                    state_d = ST_DONE;
                    drv_d   = '0;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                    pat_d   = pat_q + 1'b1;
                    drv_d   = pat_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                drv_d   = '0;
            end
        endcase

        // Abort overrides sequencing but keeps whatever the current SAMPLE just recorded.
        if (abort && is_busy(state_q)) begin
            state_d = ST_IDLE;
            drv_d   = '0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            mode_q    <= 1'b0;
            set_cnt_q <= '0;
            drv_q     <= '0;
            map_q     <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            mode_q    <= mode_d;
            set_cnt_q <= set_cnt_d;
            drv_q     <= drv_d;
            map_q     <= map_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
        end
    end

    assign {dut_a, dut_b, dut_c} = drv_q;
    assign busy        = is_busy(state_q);
    assign done        = (state_q == ST_DONE);
    assign result_map  = map_q;
    assign err_cnt     = err_q;
    assign pass        = pass_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_smpl_circuit_seq.sv
// Bench for smpl_circuit_seq: two instances (settle 2 and settle 0) share stimulus and
// each drives its own emulated smpl_circuit with injectable per-pattern x/y flips.
module tb_smpl_circuit_seq;

  localparam int S0  = 2;
  localparam int S1  = 0;
  localparam int WIN = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, abort;
  logic [2:0] pattern_in;
  logic [7:0] fx, fy;

  logic [1:0] a_w, b_w, c_w, x_w, y_w, busy_w, done_w, pass_w;
  logic [1:0][15:0] map_w;
  logic [1:0][3:0] err_w;
  logic [1:0][2:0] st_w;

  // emulated smpl_circuit per instance, with optional output flips per pattern
  assign x_w[0] = ((a_w[0] & b_w[0]) | ~c_w[0]) ^ fx[{a_w[0], b_w[0], c_w[0]}];
  assign y_w[0] = (~c_w[0]) ^ fy[{a_w[0], b_w[0], c_w[0]}];
  assign x_w[1] = ((a_w[1] & b_w[1]) | ~c_w[1]) ^ fx[{a_w[1], b_w[1], c_w[1]}];
  assign y_w[1] = (~c_w[1]) ^ fy[{a_w[1], b_w[1], c_w[1]}];

  smpl_circuit_seq #(.SETTLE_CYCLES(S0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pattern_in(pattern_in), .abort(abort),
    .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_c(c_w[0]), .dut_x(x_w[0]), .dut_y(y_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .result_map(map_w[0]), .err_cnt(err_w[0]),
    .pass(pass_w[0]), .dbg_state_o(st_w[0])
  );

  smpl_circuit_seq #(.SETTLE_CYCLES(S1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pattern_in(pattern_in), .abort(abort),
    .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_c(c_w[1]), .dut_x(x_w[1]), .dut_y(y_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .result_map(map_w[1]), .err_cnt(err_w[1]),
    .pass(pass_w[1]), .dbg_state_o(st_w[1])
  );

  int n_checks = 0;
  int n_fail = 0;

  int busy_n[2], done_at[2], done_n[2], abc_bad[2];
  bit clear_ok[2];
  logic snap_busy[2], snap_done[2], snap_pass[2];
  logic [2:0] snap_abc[2];
  logic [15:0] snap_map[2];
  logic [3:0] snap_err[2];

  typedef struct {
    bit m;
    logic [2:0] pat;
    logic [7:0] fx;
    logic [7:0] fy;
    logic [15:0] exp_map;
    logic [3:0] exp_err;
    bit exp_pass;
  } vec_t;

  vec_t vt[6];

  function automatic logic [2:0] abc(input int d);
    return {a_w[d], b_w[d], c_w[d]};
  endfunction

  function automatic int per_of(input int d);
    return ((d == 0) ? S0 : S1) + 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: each visited pattern records {y,x}; any flipped output is one mismatch.
  task automatic model(input bit m, input logic [2:0] pat, input logic [7:0] fxv,
                       input logic [7:0] fyv, output logic [15:0] map, output logic [3:0] err,
                       output bit ps);
    int a, b, c, gx, gy;
    map = '0;
    err = '0;
    for (int p = 0; p < 8; p++) begin
      if (!m || (p == int'(pat))) begin
        a = (p / 4) % 2;
        b = (p / 2) % 2;
        c = p % 2;
        gx = ((a == 1) && (b == 1)) || (c == 0) ? 1 : 0;
        gy = (c == 0) ? 1 : 0;
        map[2*p]   = 1'(gx) ^ fxv[p];
        map[2*p+1] = 1'(gy) ^ fyv[p];
        if (fxv[p] || fyv[p]) err = err + 4'd1;
      end
    end
    ps = (err == 0);
  endtask

  task automatic run_seq(input bit m, input logic [2:0] pat, input logic [7:0] fxv,
                         input logic [7:0] fyv, input int restart_cyc, input int abort_cyc,
                         input int rst_cyc);
    int snap_cyc;
    snap_cyc = (abort_cyc > 0) ? abort_cyc + 1 : ((rst_cyc > 0) ? rst_cyc + 1 : -1);
    for (int d = 0; d < 2; d++) begin
      busy_n[d] = 0; done_at[d] = -1; done_n[d] = 0; abc_bad[d] = 0; clear_ok[d] = 0;
    end
    fx = fxv; fy = fyv; mode = m; pattern_in = pat;
    start = 1'b1;
    abort = (abort_cyc == 0);
    @(negedge clk);
    for (int k = 1; k <= WIN; k++) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] exp_abc;
        exp_abc = m ? pat : 3'((k - 1) / per_of(d));
        if (k == 1)
          clear_ok[d] = (map_w[d] == 16'h0) && (err_w[d] == 4'h0) && !pass_w[d] && (abc(d) == exp_abc);
        if (busy_w[d]) begin
          busy_n[d]++;
          if (abc(d) !== exp_abc) abc_bad[d]++;
        end
        if (done_w[d]) begin
          done_n[d]++;
          if (done_at[d] < 0) done_at[d] = k;
        end
        if (k == snap_cyc) begin
          snap_busy[d] = busy_w[d]; snap_done[d] = done_w[d]; snap_pass[d] = pass_w[d];
          snap_abc[d] = abc(d); snap_map[d] = map_w[d]; snap_err[d] = err_w[d];
        end
      end
      if (k == 1) begin
        mode = ~m;
        pattern_in = ~pat;
      end
      start = (k == restart_cyc);
      abort = (k == abort_cyc);
      rst = (k == rst_cyc);
      @(negedge clk);
    end
  endtask

  task automatic check_run(input string name, input bit m, input logic [15:0] em,
                           input logic [3:0] ee, input bit ep);
    int eb;
    for (int d = 0; d < 2; d++) begin
      eb = m ? per_of(d) : 8 * per_of(d);
      check($sformatf("%s d%0d busy_cycles", name, d), busy_n[d], eb);
      check($sformatf("%s d%0d done_cycle", name, d), done_at[d], eb + 1);
      check($sformatf("%s d%0d done_pulses", name, d), done_n[d], 1);
      check($sformatf("%s d%0d abc_track", name, d), abc_bad[d], 0);
      check($sformatf("%s d%0d accept_clear", name, d), clear_ok[d], 1);
      check($sformatf("%s d%0d result_map", name, d), map_w[d], em);
      check($sformatf("%s d%0d err_cnt", name, d), err_w[d], ee);
      check($sformatf("%s d%0d pass", name, d), pass_w[d], ep);
      check($sformatf("%s d%0d abc_end", name, d), abc(d), 0);
    end
  endtask

  initial begin
    logic [15:0] em;
    logic [3:0] ee;
    bit ep;

    vt[0] = '{m: 1'b0, pat: 3'd0, fx: 8'h00, fy: 8'h00, exp_map: 16'h7333, exp_err: 4'd0, exp_pass: 1'b1};
    vt[1] = '{m: 1'b0, pat: 3'd0, fx: 8'h00, fy: 8'h55, exp_map: 16'h5111, exp_err: 4'd4, exp_pass: 1'b0};
    vt[2] = '{m: 1'b1, pat: 3'd7, fx: 8'h00, fy: 8'h00, exp_map: 16'h4000, exp_err: 4'd0, exp_pass: 1'b1};
    vt[3] = '{m: 1'b1, pat: 3'd0, fx: 8'h01, fy: 8'h00, exp_map: 16'h0002, exp_err: 4'd1, exp_pass: 1'b0};
    vt[4] = '{m: 1'b0, pat: 3'd0, fx: 8'h80, fy: 8'h00, exp_map: 16'h3333, exp_err: 4'd1, exp_pass: 1'b0};
    vt[5] = '{m: 1'b1, pat: 3'd5, fx: 8'h00, fy: 8'hFF, exp_map: 16'h0800, exp_err: 4'd1, exp_pass: 1'b0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; pattern_in = 3'd0; fx = 8'h0; fy = 8'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d outputs", d),
            {abc(d), busy_w[d], done_w[d], pass_w[d], err_w[d], map_w[d]}, 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_seq(vt[i].m, vt[i].pat, vt[i].fx, vt[i].fy, -1, -1, -1);
      check_run($sformatf("vec%0d", i), vt[i].m, vt[i].exp_map, vt[i].exp_err, vt[i].exp_pass);
    end

    for (int i = 0; i < 16; i++) begin
      bit m;
      logic [2:0] pat;
      logic [7:0] fxv, fyv;
      m = 1'($urandom_range(0, 1));
      pat = 3'($urandom_range(0, 7));
      fxv = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      fyv = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      model(m, pat, fxv, fyv, em, ee, ep);
      run_seq(m, pat, fxv, fyv, -1, -1, -1);
      check_run($sformatf("rnd%0d", i), m, em, ee, ep);
    end

    // start pulsed mid-sweep is ignored
    run_seq(1'b0, 3'd0, 8'h00, 8'h00, 10, -1, -1);
    check_run("restart_ignored", 1'b0, 16'h7333, 4'd0, 1'b1);

    // start and abort together in IDLE: start wins
    run_seq(1'b0, 3'd0, 8'h00, 8'h00, -1, 0, -1);
    check_run("start_abort_idle", 1'b0, 16'h7333, 4'd0, 1'b1);

    // abort while idle leaves the held result alone
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("idle_abort d%0d pass", d), pass_w[d], 1);
      check($sformatf("idle_abort d%0d map", d), map_w[d], 16'h7333);
    end

    // abort in cycle 12 of a sweep with y faults on even patterns
    run_seq(1'b0, 3'd0, 8'h00, 8'h55, -1, 12, -1);
    check("abort d0 busy", snap_busy[0], 0);
    check("abort d0 done", snap_done[0], 0);
    check("abort d0 abc", snap_abc[0], 0);
    check("abort d0 pass", snap_pass[0], 0);
    check("abort d0 map", snap_map[0], 16'h0011);
    check("abort d0 err", snap_err[0], 2);
    check("abort d0 done_pulses", done_n[0], 0);
    check("abort d0 map_kept", map_w[0], 16'h0011);

    // synchronous reset in cycle 20 of a sweep
    run_seq(1'b0, 3'd0, 8'h00, 8'h00, -1, -1, 20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst d%0d outputs", d),
            {snap_abc[d], snap_busy[d], snap_done[d], snap_pass[d], snap_err[d], snap_map[d]}, 0);
    end
    check("midrst d0 done_pulses", done_n[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
